mb_axil_reg_slave: RTL and testbench

- AXI4-Lite responder (slave) register bank attached to the MicroBlaze SoC's peripheral bus; the SoC processor is the initiator.
- Exposes NUM_REGS read/write 32-bit control registers to fabric logic, plus one read-only status word sampled from fabric.
- Write and read channels are independent; one outstanding transaction per direction.

---
 rtl/mb_axil_pkg.sv | 22 ++
 rtl/mb_axil_reg_slave.sv | 158 +++++++++++++++
 tb/tb_mb_axil_reg_slave.sv | 368 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mb_axil_pkg.sv
// Shared AXI4-Lite constants and the byte-lane merge used by register writes.
package mb_axil_pkg;

   localparam int DATA_W = 32;
   localparam int STRB_W = 4;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   // Replace only the byte lanes whose strobe bit is set.
   function automatic logic [DATA_W-1:0] merge_bytes(input logic [DATA_W-1:0] old_v,
                                                     input logic [DATA_W-1:0] new_v,
                                                     input logic [STRB_W-1:0] strb);
      logic [DATA_W-1:0] res;
      res = old_v;
      for (int b = 0; b < STRB_W; b++) begin
         if (strb[b]) res[8*b +: 8] = new_v[8*b +: 8];
      end
      return res;
   endfunction

endpackage

// File: rtl/mb_axil_reg_slave.sv
// AXI4-Lite register bank: NUM_REGS RW control words plus a read-only status word.
// Optional macro MB_AXIL_REG_IRQ_EN adds an IRQ_MASK register and a registered IRQ output.
module mb_axil_reg_slave
   import mb_axil_pkg::*;
#(
   parameter int ADDR_W   = 8,
   parameter int NUM_REGS = 4
) (
   input  logic                       CLK,
   input  logic                       RESET,
   input  logic [ADDR_W-1:0]          S_AXI_AWADDR,
   input  logic                       S_AXI_AWVALID,
   output logic                       S_AXI_AWREADY,
   input  logic [DATA_W-1:0]          S_AXI_WDATA,
   input  logic [STRB_W-1:0]          S_AXI_WSTRB,
   input  logic                       S_AXI_WVALID,
   output logic                       S_AXI_WREADY,
   output logic [1:0]                 S_AXI_BRESP,
   output logic                       S_AXI_BVALID,
   input  logic                       S_AXI_BREADY,
   input  logic [ADDR_W-1:0]          S_AXI_ARADDR,
   input  logic                       S_AXI_ARVALID,
   output logic                       S_AXI_ARREADY,
   output logic [DATA_W-1:0]          S_AXI_RDATA,
   output logic [1:0]                 S_AXI_RRESP,
   output logic                       S_AXI_RVALID,
   input  logic                       S_AXI_RREADY,
`ifdef MB_AXIL_REG_IRQ_EN
   output logic                       IRQ,
`endif
   output logic [DATA_W*NUM_REGS-1:0] REG_OUT,
   input  logic [DATA_W-1:0]          STATUS_IN
);

   localparam int IDX_W = ADDR_W - 2;
   localparam logic [IDX_W-1:0] STATUS_IDX = IDX_W'(NUM_REGS);
`ifdef MB_AXIL_REG_IRQ_EN
   localparam logic [IDX_W-1:0] MASK_IDX   = IDX_W'(NUM_REGS + 1);
   logic [DATA_W-1:0] irq_mask;
`endif

   logic [DATA_W-1:0] regs [NUM_REGS];
   logic              aw_full, w_full;
   logic [IDX_W-1:0]  aw_idx;
   logic [DATA_W-1:0] w_data;
   logic [STRB_W-1:0] w_strb;
   logic              aw_hs, w_hs, ar_hs, wr_ok;
   logic [IDX_W-1:0]  rd_idx;
   logic [DATA_W-1:0] rd_word;
   logic [1:0]        rd_resp;
   logic              unused_addr_bits;

   // A transfer happens on an edge where VALID and READY are both high; VALID
   // and payload then hold steady until that edge. READY is forced low in reset.
   assign S_AXI_AWREADY = !RESET && !aw_full && !S_AXI_BVALID;
   assign S_AXI_WREADY  = !RESET && !w_full  && !S_AXI_BVALID;
   assign S_AXI_ARREADY = !RESET && !S_AXI_RVALID;
   assign aw_hs = S_AXI_AWVALID && S_AXI_AWREADY;
   assign w_hs  = S_AXI_WVALID  && S_AXI_WREADY;
   assign ar_hs = S_AXI_ARVALID && S_AXI_ARREADY;
   assign rd_idx = S_AXI_ARADDR[ADDR_W-1:2];
   assign unused_addr_bits = ^{S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

   for (genvar g = 0; g < NUM_REGS; g++) begin : g_out
      assign REG_OUT[DATA_W*g +: DATA_W] = regs[g];
   end

   always_comb begin
      wr_ok = (aw_idx < STATUS_IDX);
`ifdef MB_AXIL_REG_IRQ_EN
      if (aw_idx == MASK_IDX) wr_ok = 1'b1;
`endif
   end

   always_comb begin
      rd_word = '0;
      rd_resp = RESP_SLVERR;
      for (int i = 0; i < NUM_REGS; i++) begin
         if (rd_idx == IDX_W'(i)) begin
            rd_word = regs[i];
            rd_resp = RESP_OKAY;
         end
      end
      if (rd_idx == STATUS_IDX) begin
         rd_word = STATUS_IN;
         rd_resp = RESP_OKAY;
      end
`ifdef MB_AXIL_REG_IRQ_EN
      if (rd_idx == MASK_IDX) begin
         rd_word = irq_mask;
         rd_resp = RESP_OKAY;
      end
`endif
   end

   // Commit happens the edge after both holding slots are full.
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         aw_full      <= 1'b0;
         w_full       <= 1'b0;
         aw_idx       <= '0;
         w_data       <= '0;
         w_strb       <= '0;
         S_AXI_BVALID <= 1'b0;
         S_AXI_BRESP  <= RESP_OKAY;
         for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
`ifdef MB_AXIL_REG_IRQ_EN
         irq_mask     <= '0;
`endif
      end else begin
         if (S_AXI_BVALID && S_AXI_BREADY) S_AXI_BVALID <= 1'b0;
         if (aw_full && w_full) begin
            aw_full      <= 1'b0;
            w_full       <= 1'b0;
            S_AXI_BVALID <= 1'b1;
            S_AXI_BRESP  <= wr_ok ? RESP_OKAY : RESP_SLVERR;
            for (int i = 0; i < NUM_REGS; i++) begin
               if (aw_idx == IDX_W'(i)) regs[i] <= merge_bytes(regs[i], w_data, w_strb);
            end
`ifdef MB_AXIL_REG_IRQ_EN
            if (aw_idx == MASK_IDX) irq_mask <= merge_bytes(irq_mask, w_data, w_strb);
`endif
         end else begin
            if (aw_hs) begin
               aw_full <= 1'b1;
               aw_idx  <= S_AXI_AWADDR[ADDR_W-1:2];
            end
            if (w_hs) begin
               w_full <= 1'b1;
               w_data <= S_AXI_WDATA;
               w_strb <= S_AXI_WSTRB;
            end
         end
      end
   end

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         S_AXI_RVALID <= 1'b0;
         S_AXI_RDATA  <= '0;
         S_AXI_RRESP  <= RESP_OKAY;
      end else if (ar_hs) begin
         S_AXI_RVALID <= 1'b1;
         S_AXI_RDATA  <= rd_word;
         S_AXI_RRESP  <= rd_resp;
      end else if (S_AXI_RVALID && S_AXI_RREADY) begin
         S_AXI_RVALID <= 1'b0;
      end
   end

`ifdef MB_AXIL_REG_IRQ_EN
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) IRQ <= 1'b0;
      else       IRQ <= |(STATUS_IN & irq_mask);
   end
`endif

endmodule

// File: tb/tb_mb_axil_reg_slave.sv
// Directed bench for mb_axil_reg_slave (default NUM_REGS=4, ADDR_W=8).
module tb_mb_axil_reg_slave;

   logic         clk, rst;
   logic [7:0]   awaddr, araddr;
   logic         awvalid, awready, wvalid, wready, bvalid, bready;
   logic         arvalid, arready, rvalid, rready;
   logic [31:0]  wdata, rdata, status_in;
   logic [3:0]   wstrb;
   logic [1:0]   bresp, rresp;
   logic [127:0] reg_out;
`ifdef MB_AXIL_REG_IRQ_EN
   logic         irq;
`endif

   int checks = 0;
   int errors = 0;
   logic [31:0] exp_q[$];

   mb_axil_reg_slave #(.ADDR_W(8), .NUM_REGS(4)) dut (
      .CLK(clk), .RESET(rst),
      .S_AXI_AWADDR(awaddr), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
      .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
      .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
      .S_AXI_ARADDR(araddr), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
      .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready),
`ifdef MB_AXIL_REG_IRQ_EN
      .IRQ(irq),
`endif
      .REG_OUT(reg_out), .STATUS_IN(status_in)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // driver tasks
   task automatic do_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s,
                           output logic [1:0] resp);
      logic aw_done, w_done, aw_fire, w_fire;
      int cnt;
      awaddr = a; wdata = d; wstrb = s;
      awvalid = 1'b1; wvalid = 1'b1;
      aw_done = 1'b0; w_done = 1'b0; cnt = 0;
      while (!(aw_done && w_done) && cnt < 50) begin
         aw_fire = awvalid && awready;
         w_fire  = wvalid && wready;
         tick();
         if (aw_fire) begin awvalid = 1'b0; aw_done = 1'b1; end
         if (w_fire)  begin wvalid  = 1'b0; w_done  = 1'b1; end
         cnt++;
      end
      awvalid = 1'b0; wvalid = 1'b0;
      cnt = 0;
      while (!bvalid && cnt < 50) begin tick(); cnt++; end
      if (!bvalid) begin
         checks++; errors++;
         $display("FAIL write_timeout addr=%h got bvalid=0 required bvalid=1", a);
      end
      resp = bresp;
      bready = 1'b1;
      tick();
      bready = 1'b0;
   endtask

   task automatic do_read(input logic [7:0] a, output logic [31:0] d, output logic [1:0] resp);
      logic fire;
      int cnt;
      araddr = a; arvalid = 1'b1; cnt = 0; fire = 1'b0;
      while (!fire && cnt < 50) begin
         fire = arready;
         tick();
         cnt++;
      end
      arvalid = 1'b0;
      cnt = 0;
      while (!rvalid && cnt < 50) begin tick(); cnt++; end
      if (!rvalid) begin
         checks++; errors++;
         $display("FAIL read_timeout addr=%h got rvalid=0 required rvalid=1", a);
      end
      d = rdata; resp = rresp;
      rready = 1'b1;
      tick();
      rready = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) tick();
      checks++;
      if ({awready, wready, arready, bvalid, rvalid} !== 5'b0) begin
         errors++;
         $display("FAIL reset_ctrl got %b required 00000", {awready, wready, arready, bvalid, rvalid});
      end
      checks++;
      if ({reg_out, rdata, bresp, rresp} !== '0) begin
         errors++;
         $display("FAIL reset_data got reg_out=%h rdata=%h bresp=%b rresp=%b required 0", reg_out, rdata, bresp, rresp);
      end
      rst = 1'b0;
      #1;
      checks++;
      if ({awready, wready, arready} !== 3'b111) begin
         errors++;
         $display("FAIL reset_release_ready got %b required 111", {awready, wready, arready});
      end
   endtask

   task automatic test_same_cycle();
      awaddr = 8'h04; wdata = 32'hDEADBEEF; wstrb = 4'hF;
      awvalid = 1'b1; wvalid = 1'b1;
      tick();
      awvalid = 1'b0; wvalid = 1'b0;
      checks++;
      if (bvalid !== 1'b0) begin
         errors++; $display("FAIL same_cycle_early_bvalid got %b required 0", bvalid);
      end
      tick();
      checks++;
      if (bvalid !== 1'b1 || bresp !== 2'b00) begin
         errors++; $display("FAIL same_cycle_bresp got bvalid=%b bresp=%b required 1/00", bvalid, bresp);
      end
      checks++;
      if (reg_out[63:32] !== 32'hDEADBEEF) begin
         errors++; $display("FAIL same_cycle_reg1 got %h required deadbeef", reg_out[63:32]);
      end
      bready = 1'b1;
      tick();
      bready = 1'b0;
      checks++;
      if (bvalid !== 1'b0) begin
         errors++; $display("FAIL same_cycle_bclear got %b required 0", bvalid);
      end
   endtask

   task automatic test_w_first();
      wdata = 32'h12345678; wstrb = 4'hF; wvalid = 1'b1;
      tick();
      wvalid = 1'b0;
      checks++;
      if (wready !== 1'b0 || awready !== 1'b1) begin
         errors++; $display("FAIL w_first_slot got wready=%b awready=%b required 0/1", wready, awready);
      end
      repeat (2) tick();
      awaddr = 8'h00; awvalid = 1'b1;
      tick();
      awvalid = 1'b0;
      tick();
      checks++;
      if (bvalid !== 1'b1 || reg_out[31:0] !== 32'h12345678) begin
         errors++; $display("FAIL w_first_commit got bvalid=%b reg0=%h required 1/12345678", bvalid, reg_out[31:0]);
      end
      awaddr = 8'h08; wdata = 32'h00000BAD; awvalid = 1'b1; wvalid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         checks++;
         if ({awready, wready, bvalid} !== 3'b001) begin
            errors++; $display("FAIL w_first_hold cyc=%0d got aw/w/b=%b required 001", i, {awready, wready, bvalid});
         end
         tick();
      end
      awvalid = 1'b0; wvalid = 1'b0;
      bready = 1'b1;
      tick();
      bready = 1'b0;
      checks++;
      if (bvalid !== 1'b0 || reg_out[95:64] !== 32'h0) begin
         errors++; $display("FAIL w_first_release got bvalid=%b reg2=%h required 0/0", bvalid, reg_out[95:64]);
      end
   endtask

   task automatic test_strobe();
      logic [1:0] r;
      do_write(8'h00, 32'hFFFFFFFF, 4'hF, r);
      do_write(8'h00, 32'h00000000, 4'b0101, r);
      checks++;
      if (reg_out[31:0] !== 32'hFF00FF00 || r !== 2'b00) begin
         errors++; $display("FAIL strobe_0101 got reg0=%h resp=%b required ff00ff00/00", reg_out[31:0], r);
      end
      do_write(8'h03, 32'h12345678, 4'b0000, r);
      checks++;
      if (reg_out[31:0] !== 32'hFF00FF00 || r !== 2'b00) begin
         errors++; $display("FAIL strobe_0000 got reg0=%h resp=%b required ff00ff00/00", reg_out[31:0], r);
      end
   endtask

   task automatic test_status();
      logic [31:0] d;
      logic [1:0]  r;
      status_in = 32'hA5A5A5A5;
      do_read(8'h10, d, r);
      checks++;
      if (d !== 32'hA5A5A5A5 || r !== 2'b00) begin
         errors++; $display("FAIL status_read got %h/%b required a5a5a5a5/00", d, r);
      end
      do_write(8'h10, 32'h0, 4'hF, r);
      checks++;
      if (r !== 2'b10 || reg_out !== {32'h0, 32'h0, 32'hDEADBEEF, 32'hFF00FF00}) begin
         errors++; $display("FAIL status_write got resp=%b reg_out=%h", r, reg_out);
      end
      do_read(8'h10, d, r);
      checks++;
      if (d !== 32'hA5A5A5A5 || r !== 2'b00) begin
         errors++; $display("FAIL status_reread got %h/%b required a5a5a5a5/00", d, r);
      end
      do_read(8'h3C, d, r);
      checks++;
      if (d !== 32'h0 || r !== 2'b10) begin
         errors++; $display("FAIL unmapped_read got %h/%b required 0/10", d, r);
      end
`ifndef MB_AXIL_REG_IRQ_EN
      do_read(8'h14, d, r);
      checks++;
      if (d !== 32'h0 || r !== 2'b10) begin
         errors++; $display("FAIL mask_slot_unmapped got %h/%b required 0/10", d, r);
      end
      do_write(8'h17, 32'hFFFFFFFF, 4'hF, r);
      checks++;
      if (r !== 2'b10) begin
         errors++; $display("FAIL mask_slot_write got resp=%b required 10", r);
      end
`endif
   endtask

   task automatic test_read_hold();
      araddr = 8'h04; arvalid = 1'b1;
      tick();
      arvalid = 1'b0;
      for (int i = 0; i < 4; i++) begin
         status_in = (i % 2 == 0) ? 32'h0F0F0F0F : 32'hF0F0F0F0;
         checks++;
         if (rvalid !== 1'b1 || rdata !== 32'hDEADBEEF || rresp !== 2'b00 || arready !== 1'b0) begin
            errors++;
            $display("FAIL read_hold cyc=%0d got rvalid=%b rdata=%h rresp=%b arready=%b required 1/deadbeef/00/0",
                     i, rvalid, rdata, rresp, arready);
         end
         tick();
      end
      rready = 1'b1;
      tick();
      rready = 1'b0;
      checks++;
      if (rvalid !== 1'b0 || arready !== 1'b1) begin
         errors++; $display("FAIL read_release got rvalid=%b arready=%b required 0/1", rvalid, arready);
      end
   endtask

   task automatic test_simultaneous();
      logic [31:0] d;
      logic [1:0]  r;
      awaddr = 8'h0C; wdata = 32'h00000055; wstrb = 4'hF;
      awvalid = 1'b1; wvalid = 1'b1;
      tick();
      awvalid = 1'b0; wvalid = 1'b0;
      araddr = 8'h0C; arvalid = 1'b1;
      tick();
      arvalid = 1'b0;
      checks++;
      if (rvalid !== 1'b1 || rdata !== 32'h0 || reg_out[127:96] !== 32'h55) begin
         errors++; $display("FAIL simultaneous got rvalid=%b rdata=%h reg3=%h required 1/0/55", rvalid, rdata, reg_out[127:96]);
      end
      rready = 1'b1; bready = 1'b1;
      tick();
      rready = 1'b0; bready = 1'b0;
      do_read(8'h0C, d, r);
      checks++;
      if (d !== 32'h55 || r !== 2'b00) begin
         errors++; $display("FAIL simultaneous_after got %h/%b required 55/00", d, r);
      end
   endtask

   task automatic test_back_to_back();
      logic [31:0] d, e;
      logic [1:0]  r;
      exp_q.push_back(32'hFF00FF00);
      exp_q.push_back(32'hDEADBEEF);
      exp_q.push_back(32'h00000000);
      exp_q.push_back(32'h00000055);
      for (int i = 0; i < 4; i++) begin
         do_read(8'(4 * i), d, r);
         e = exp_q.pop_front();
         checks++;
         if (d !== e || r !== 2'b00) begin
            errors++; $display("FAIL b2b_read reg%0d got %h/%b required %h/00", i, d, r, e);
         end
      end
   endtask

`ifdef MB_AXIL_REG_IRQ_EN
   task automatic test_irq();
      logic [31:0] d;
      logic [1:0]  r;
      status_in = 32'h0;
      do_write(8'h14, 32'h1, 4'hF, r);
      checks++;
      if (r !== 2'b00 || irq !== 1'b0) begin
         errors++; $display("FAIL irq_mask_write got resp=%b irq=%b required 00/0", r, irq);
      end
      status_in = 32'h1;
      tick();
      checks++;
      if (irq !== 1'b1) begin
         errors++; $display("FAIL irq_assert got %b required 1", irq);
      end
      status_in = 32'h2;
      tick();
      checks++;
      if (irq !== 1'b0) begin
         errors++; $display("FAIL irq_deassert got %b required 0", irq);
      end
      do_read(8'h14, d, r);
      checks++;
      if (d !== 32'h1 || r !== 2'b00) begin
         errors++; $display("FAIL irq_mask_read got %h/%b required 1/00", d, r);
      end
   endtask
`endif

   task automatic test_reset_mid();
      awaddr = 8'h08; awvalid = 1'b1;
      tick();
      awvalid = 1'b0;
      checks++;
      if (awready !== 1'b0 || wready !== 1'b1) begin
         errors++; $display("FAIL mid_aw_pending got awready=%b wready=%b required 0/1", awready, wready);
      end
      rst = 1'b1;
      #1;
      checks++;
      if ({awready, wready, arready, bvalid, rvalid, reg_out, rdata} !== '0) begin
         errors++; $display("FAIL mid_reset_outputs got reg_out=%h ctl=%b", reg_out, {awready, wready, arready, bvalid, rvalid});
      end
      tick();
      rst = 1'b0;
      for (int i = 0; i < 5; i++) begin
         tick();
         checks++;
         if (bvalid !== 1'b0 || rvalid !== 1'b0) begin
            errors++; $display("FAIL mid_stray_resp cyc=%0d got bvalid=%b rvalid=%b required 0/0", i, bvalid, rvalid);
         end
      end
   endtask

   initial begin
      rst = 1'b1; awaddr = '0; awvalid = 1'b0; wdata = '0; wstrb = '0; wvalid = 1'b0;
      bready = 1'b0; araddr = '0; arvalid = 1'b0; rready = 1'b0; status_in = '0;
      test_reset();
      test_same_cycle();
      test_w_first();
      test_strobe();
      test_status();
      test_read_hold();
      test_simultaneous();
      test_back_to_back();
`ifdef MB_AXIL_REG_IRQ_EN
      test_irq();
`endif
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
